// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter between the fetch and load/store requesters for the single
// shared memory port: sequences a read handshake or a one-cycle write, then acks the winner.
module mem_port_arbiter #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        IReq,
    input  logic [31:0] IAddr,
    output logic        IAck,
    output logic [31:0] IRData,
    output logic        IErr,
    input  logic        DReq,
    input  logic        DWe,
    input  logic [31:0] DAddr,
    input  logic [31:0] DWData,
    input  logic [3:0]  DStrb,
    output logic        DAck,
    output logic [31:0] DRData,
    output logic        DErr,
    output logic        RRdy,
    output logic [31:0] RAddr,
    output logic [31:0] RWData,
    output logic        RWEn,
    output logic [3:0]  RWStrobe,
    input  logic        RVld,
    input  logic [31:0] RData,
    output logic        Busy
);

    localparam int unsigned CW = 8;

    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

    state_t        state;
    logic          owner;       // 1 = load/store side owns the port
    logic          last_owner;  // 1 = load/store side won the previous grant
    logic [CW-1:0] cnt;
    logic          grant_d;
    logic          rd_done;

    // On a tie the side that did not win last time is granted.
    assign grant_d = DReq && (!IReq || !last_owner);
    assign rd_done = RVld || (cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_owner <= 1'b1;
            cnt        <= '0;
            IAck       <= 1'b0;
            IErr       <= 1'b0;
            IRData     <= '0;
            DAck       <= 1'b0;
            DErr       <= 1'b0;
            DRData     <= '0;
            RRdy       <= 1'b0;
            RAddr      <= '0;
            RWData     <= '0;
            RWEn       <= 1'b0;
            RWStrobe   <= '0;
            Busy       <= 1'b0;
        end else begin
            IAck <= 1'b0;
            DAck <= 1'b0;
            IErr <= 1'b0;
            DErr <= 1'b0;
            case (state)
                IDLE: begin
                    if (IReq || DReq) begin
                        owner <= grant_d;
                        cnt   <= '0;
                        Busy  <= 1'b1;
                        RAddr <= grant_d ? DAddr : IAddr;
                        if (grant_d && DWe) begin
                            state    <= WR;
                            RWEn     <= 1'b1;
                            RWData   <= DWData;
                            RWStrobe <= DStrb;
                        end else begin
                            state <= RD;
                            RRdy  <= 1'b1;
                        end
                    end
                end
                RD: begin
                    // RVld takes priority over a timeout in the same cycle.
                    if (rd_done) begin
                        state <= RESP;
                        RRdy  <= 1'b0;
                        RAddr <= '0;
                        if (owner) begin
                            DAck   <= 1'b1;
                            DErr   <= !RVld;
                            DRData <= RVld ? RData : 32'd0;
                        end else begin
                            IAck   <= 1'b1;
                            IErr   <= !RVld;
                            IRData <= RVld ? RData : 32'd0;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                WR: begin
                    state    <= RESP;
                    RWEn     <= 1'b0;
                    RWData   <= '0;
                    RWStrobe <= '0;
                    RAddr    <= '0;
                    DAck     <= owner;
                    IAck     <= !owner;
                end
                RESP: begin
                    state      <= IDLE;
                    Busy       <= 1'b0;
                    last_owner <= owner;
                end
                default: begin
                    state <= IDLE;
                    Busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small word memory model whose
// read latency can be set or disabled to exercise the timeout path.
module tb_mem_port_arbiter;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        IReq, DReq, DWe;
    logic [31:0] IAddr, DAddr, DWData;
    logic [3:0]  DStrb;
    logic        IAck, IErr, DAck, DErr, RRdy, RWEn, Busy;
    logic [31:0] IRData, DRData, RAddr, RWData;
    logic [3:0]  RWStrobe;
    logic        RVld = 1'b0;
    logic [31:0] RData = 32'd0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .IReq(IReq), .IAddr(IAddr), .IAck(IAck), .IRData(IRData), .IErr(IErr),
        .DReq(DReq), .DWe(DWe), .DAddr(DAddr), .DWData(DWData), .DStrb(DStrb),
        .DAck(DAck), .DRData(DRData), .DErr(DErr),
        .RRdy(RRdy), .RAddr(RAddr), .RWData(RWData), .RWEn(RWEn), .RWStrobe(RWStrobe),
        .RVld(RVld), .RData(RData), .Busy(Busy)
    );

    // Memory model: RVld pulses once RRdy has been seen for mem_lat edges.
    logic [31:0] mem [0:1023];
    int          mem_lat = 1;
    bit          mem_en  = 1'b1;
    int          rcnt    = 0;

    always @(posedge clk) begin
        if (RWEn)
            for (int b = 0; b < 4; b++)
                if (RWStrobe[b]) mem[RAddr[9:0]][8*b +: 8] <= RWData[8*b +: 8];
        RData <= mem[RAddr[9:0]];
        RVld  <= mem_en && RRdy && (rcnt == mem_lat - 1);
        rcnt  <= RRdy ? rcnt + 1 : 0;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    int          t_lat, t_rrdy, t_wen;
    logic [31:0] t_rdata, t_waddr, t_wdata;
    logic [3:0]  t_wstrb;
    logic        t_err, t_other;

    // One requester transaction; req dropped in the cycle after its ack.
    task automatic txn(input logic d, input logic we, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] st);
        @(posedge clk); #1;
        if (d) begin
            DReq = 1'b1; DWe = we; DAddr = a; DWData = wd; DStrb = st;
        end else begin
            IReq = 1'b1; IAddr = a;
        end
        t_lat = -1; t_rrdy = 0; t_wen = 0; t_other = 1'b0;
        t_rdata = 'x; t_err = 1'bx; t_waddr = 'x; t_wdata = 'x; t_wstrb = 'x;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (RRdy) t_rrdy++;
            if (RWEn) begin
                t_wen++; t_waddr = RAddr; t_wdata = RWData; t_wstrb = RWStrobe;
            end
            if (d ? IAck : DAck) t_other = 1'b1;
            if (d ? DAck : IAck) begin
                t_lat = c; t_rdata = d ? DRData : IRData; t_err = d ? DErr : IErr;
                break;
            end
        end
        @(posedge clk); #1;
        IReq = 1'b0; DReq = 1'b0; DWe = 1'b0;
    endtask

    int       nack;
    int       both;
    logic [3:0] order;

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
        mem[10'h100] = 32'hDEADBEEF;
        mem[10'h010] = 32'h11223344;
        mem[10'h200] = 32'hCAFEF00D;
        IReq = 0; DReq = 0; DWe = 0; IAddr = 0; DAddr = 0; DWData = 0; DStrb = 0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_ctrl", 32'({IAck, DAck, IErr, DErr, RRdy, RWEn, Busy}), 32'd0);
        check("reset_raddr", RAddr, 32'd0);
        check("reset_bus", 32'({RWData != 0, RWStrobe != 0, IRData != 0, DRData != 0}), 32'd0);
        rst = 1'b0;

        // Fetch read with 1-cycle memory
        txn(1'b0, 1'b0, 32'h100, 32'd0, 4'd0);
        check("rd_lat", 32'(t_lat), 32'd3);
        check("rd_rrdy_cycles", 32'(t_rrdy), 32'd2);
        check("rd_data", t_rdata, 32'hDEADBEEF);
        check("rd_err", 32'(t_err), 32'd0);
        check("rd_other_ack", 32'(t_other), 32'd0);
        @(negedge clk);
        check("rd_hold", IRData, 32'hDEADBEEF);
        check("idle_bus", 32'({RRdy, RWEn, Busy, RAddr != 0}), 32'd0);

        // Partial store then reload
        txn(1'b1, 1'b1, 32'h10, 32'hAABBCCDD, 4'b0011);
        check("wr_lat", 32'(t_lat), 32'd2);
        check("wr_wen_cycles", 32'(t_wen), 32'd1);
        check("wr_rrdy_cycles", 32'(t_rrdy), 32'd0);
        check("wr_addr", t_waddr, 32'h10);
        check("wr_data", t_wdata, 32'hAABBCCDD);
        check("wr_strb", 32'(t_wstrb), 32'h3);
        check("wr_err", 32'(t_err), 32'd0);
        txn(1'b1, 1'b0, 32'h10, 32'd0, 4'd0);
        check("ld_lat", 32'(t_lat), 32'd3);
        check("ld_data", t_rdata, 32'h1122CCDD);

        // Memory silent: timeout after TO cycles of RRdy
        mem_en = 1'b0;
        txn(1'b1, 1'b0, 32'h100, 32'd0, 4'd0);
        check("to_lat", 32'(t_lat), 32'(TO + 1));
        check("to_rrdy_cycles", 32'(t_rrdy), 32'(TO));
        check("to_err", 32'(t_err), 32'd1);
        check("to_data", t_rdata, 32'd0);

        // RVld one cycle too late: timeout, late pulse ignored
        mem_en = 1'b1; mem_lat = TO;
        txn(1'b1, 1'b0, 32'h200, 32'd0, 4'd0);
        check("late_err", 32'(t_err), 32'd1);
        check("late_data", t_rdata, 32'd0);
        repeat (3) @(negedge clk);
        check("late_after", 32'({DAck, IAck, Busy, RRdy}), 32'd0);
        check("late_hold", DRData, 32'd0);

        // RVld exactly in the last RD cycle wins over timeout
        mem_lat = TO - 1;
        txn(1'b1, 1'b0, 32'h200, 32'd0, 4'd0);
        check("edge_lat", 32'(t_lat), 32'(TO + 1));
        check("edge_rrdy_cycles", 32'(t_rrdy), 32'(TO));
        check("edge_err", 32'(t_err), 32'd0);
        check("edge_data", t_rdata, 32'hCAFEF00D);

        // Reset during RD aborts the fetch
        mem_en = 1'b0; mem_lat = 1;
        @(posedge clk); #1;
        IReq = 1'b1; IAddr = 32'h100;
        repeat (2) @(negedge clk);
        check("pre_rst_rd", 32'({RRdy, Busy}), 32'h3);
        #2 rst = 1'b1;
        #1;
        check("async_rst", 32'({RRdy, Busy, IAck, DAck}), 32'd0);
        check("async_rst_rdata", IRData, 32'd0);
        IReq = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0; mem_en = 1'b1;
        txn(1'b0, 1'b0, 32'h100, 32'd0, 4'd0);
        check("post_rst_lat", 32'(t_lat), 32'd3);
        check("post_rst_data", t_rdata, 32'hDEADBEEF);

        // Both requesters held from reset: grants alternate starting with I
        @(posedge clk); #1;
        rst = 1'b1;
        IReq = 1'b1; IAddr = 32'h100;
        DReq = 1'b1; DWe = 1'b0; DAddr = 32'h10;
        @(posedge clk); #1;
        rst = 1'b0;
        nack = 0; both = 0; order = 4'd0;
        for (int c = 0; c < 60 && nack < 4; c++) begin
            @(negedge clk);
            if (IAck && DAck) both++;
            if (IAck || DAck) begin
                order[nack] = DAck;
                nack++;
            end
        end
        IReq = 1'b0; DReq = 1'b0;
        check("rr_acks", 32'(nack), 32'd4);
        check("rr_order", 32'(order), 32'b1010);
        check("rr_both", 32'(both), 32'd0);
        check("rr_idata", IRData, 32'hDEADBEEF);
        check("rr_ddata", DRData, 32'h1122CCDD);

        repeat (4) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester controller for the single shared memory port of the `lanzones` core. The instruction-fetch side (read-only) and the load/store side (read/write) each present a request/acknowledge interface. The arbiter picks one of them and sequences the `RRdy`/`RVld` read handshake or the one-cycle `RWEn` write onto the memory port. It then returns data or a timeout error to the winner. It sits between the core's fetch/LSU logic and the `MemoryModel`-style memory port.

## Interface
Parameters:
- `TIMEOUT`, default 16: maximum number of RD-state cycles spent waiting for `RVld`. Legal range is 2..255.

Ports:
- `clk` in 1: clock. All state changes on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `IReq` in 1: fetch request.
- `IAddr` in 32: fetch word address.
- `IAck` out 1: one-cycle fetch completion pulse.
- `IRData` out 32: fetch data. Valid while `IAck`=1 and held until the next `IAck`.
- `IErr` out 1: fetch timed out. Qualified by `IAck`.
- `DReq` in 1: load/store request.
- `DWe` in 1: 1 = store, 0 = load.
- `DAddr` in 32: load/store word address.
- `DWData` in 32: store data.
- `DStrb` in 4: store byte enables.
- `DAck` out 1: one-cycle load/store completion pulse.
- `DRData` out 32: load data. Valid while `DAck`=1 and held until the next `DAck`.
- `DErr` out 1: load timed out. Qualified by `DAck`.
- `RRdy` out 1: read request to memory.
- `RAddr` out 32: memory address.
- `RWData` out 32: memory write data.
- `RWEn` out 1: memory write enable (single cycle).
- `RWStrobe` out 4: memory byte enables.
- `RVld` in 1: memory read-data valid (single-cycle pulse).
- `RData` in 32: memory read data. Sampled only when `RVld`=1.
- `Busy` out 1: high whenever the state is not IDLE.

## Operation
- States are IDLE, RD, WR and RESP.
- IDLE:
  - No request: stay in IDLE.
  - Exactly one request: grant it.
  - Both requesting: grant the requester that did not win the previous grant (round-robin). The first tie after reset goes to I.
  - On grant: latch owner, address, write data, strobe and we. A write goes to WR; a read (I always, D with `DWe`=0) goes to RD.
- RD:
  - Drive `RRdy`=1 with `RAddr` set to the latched address.
  - On `RVld`=1: capture `RData` into the owner's rdata register, clear err, go to RESP.
  - Otherwise increment the wait counter. When it reaches `TIMEOUT`-1, write the owner's rdata register to 0, set err, and go to RESP.
- WR:
  - Drive `RWEn`=1, `RWStrobe`, `RWData` and `RAddr` for exactly one cycle, with `RRdy`=0.
  - Always go to RESP; writes never produce an error.
- RESP:
  - Pulse the owner's Ack for one cycle. The other requester's Ack stays 0.
  - Update last-owner.
  - Go to IDLE.
- Requester rules:
  - Hold Req high until Ack, then deassert it in the cycle after Ack.
  - The request inputs are latched at grant, so changing them after grant has no effect.
  - A Req that is still high in the IDLE cycle after RESP is a new request.
- `RVld` outside the RD state (for example a late response after a timeout) is ignored. `RData` is never sampled unless `RVld`=1.
- Outputs are 0 whenever they are not being driven as above: `RRdy`, `RWEn`, `RWStrobe`, `RWData` and `RAddr` are all 0 in IDLE and RESP.

## Timing
- Reset: state goes to IDLE immediately. `IAck`, `DAck`, `IErr`, `DErr`, `RRdy`, `RWEn` and `Busy` = 0. `RAddr`, `RWData`, `RWStrobe`, `IRData` and `DRData` = 0. Last-owner = D, and the wait counter = 0.
- Reset asserted mid-transaction aborts it with no Ack. The requester must re-request.
- Read with 1-cycle memory:
  - Cycle 0: Req seen in IDLE.
  - Cycle 1: `RRdy`=1.
  - Cycle 2: `RVld`=1, still in RD.
  - Cycle 3: Ack=1.
  - Latency is 3 cycles; back-to-back throughput is 1 read per 4 cycles.
- Write:
  - Cycle 0: Req seen in IDLE.
  - Cycle 1: `RWEn`=1.
  - Cycle 2: Ack=1.
- Timeout: RD lasts at most `TIMEOUT` cycles. If `RVld` arrives in the same cycle the counter reaches `TIMEOUT`-1, `RVld` wins and no error is reported.
- The wait counter is cleared on every entry to RD.

## Test plan
- Memory holds 0x100=0xDEADBEEF. `IReq`, `IAddr`=0x100 -> `RRdy` high exactly 2 cycles, `IAck` pulse 3 cycles after Req with `IRData`=0xDEADBEEF and `IErr`=0.
- `DReq`, `DWe`=1, `DAddr`=0x10, `DWData`=0xAABBCCDD, `DStrb`=4'b0011 over an old value of 0x11223344 -> a single `RWEn` cycle; a following load of 0x10 returns 0x1122CCDD.
- `IReq` and `DReq` both asserted and held continuously from reset -> grants alternate I, D, I, D. No Ack is ever given to the non-owner.
- Memory never asserts `RVld`, `TIMEOUT`=4 -> `RRdy` high 4 cycles, then `DAck`=1, `DErr`=1 and `DRData`=0. A late `RVld` afterwards changes nothing.
- `rst` pulsed during RD -> `RRdy`, `Busy` and both Acks drop to 0 asynchronously. After reset, a fresh `IReq` completes normally.
